// File: rtl/ex2_arbiter.sv
// Two-requester arbiter in front of a shared combinational ex2 unit: it registers the
// granted operands, waits SETTLE_CYCLES, then returns one selected result with valid/ready.
// Define EX2_ARB_FIXED_PRIO_EN to give requester 0 fixed priority when both requesters are valid.
module ex2_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [4:0] req0_P,
  input  logic [4:0] req0_Q,
  input  logic [2:0] req0_op,
  input  logic [4:0] req1_P,
  input  logic [4:0] req1_Q,
  input  logic [2:0] req1_op,
  output logic [4:0] alu_P,
  output logic [4:0] alu_Q,
  input  logic [6:0] alu_R,
  input  logic [3:0] alu_S,
  input  logic [7:0] alu_T,
  input  logic [4:0] alu_U,
  input  logic [4:0] alu_V,
  input  logic [5:0] alu_W,
  input  logic [4:0] alu_X,
  input  logic       alu_Y,
  input  logic       alu_Z,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic       rr_last;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic       winner;
  logic       accept;

  function automatic logic [7:0] sel_result(
    input logic [2:0] op,
    input logic [6:0] r,
    input logic [3:0] s,
    input logic [7:0] t,
    input logic [4:0] u,
    input logic [4:0] v,
    input logic [5:0] w,
    input logic [4:0] x,
    input logic       y,
    input logic       z
  );
    logic [7:0] res;
    case (op)
      3'd0:    res = {1'b0, r};
      3'd1:    res = {4'b0000, s};
      3'd2:    res = t;
      3'd3:    res = {3'b000, u};
      3'd4:    res = {3'b000, v};
      3'd5:    res = {2'b00, w};
      3'd6:    res = {3'b000, x};
      3'd7:    res = {6'b000000, z, y};
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Winner selection and the combinational grant, live only in IDLE
  always_comb begin
    winner    = 1'b0;
    accept    = 1'b0;
    req_ready = 2'b00;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
`ifdef EX2_ARB_FIXED_PRIO_EN
      2'b11:   winner = 1'b0;
`else
      2'b11:   winner = ~rr_last;
`endif
      default: winner = 1'b0;
    endcase
    if ((state == IDLE) && (req_valid != 2'b00)) begin
      accept    = 1'b1;
      req_ready = winner ? 2'b10 : 2'b01;
    end else begin
      accept    = 1'b0;
      req_ready = 2'b00;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETTLE;
        end else begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          state_next = SETTLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand, counter and response registers; busy/rsp_valid follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_P     <= 5'd0;
      alu_Q     <= 5'd0;
      op_q      <= 3'd0;
      cnt       <= 4'd0;
      rr_last   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      rsp_valid <= (state_next == RESP);
      case (state)
        IDLE: begin
          if (accept) begin
            alu_P   <= winner ? req1_P : req0_P;
            alu_Q   <= winner ? req1_Q : req0_Q;
            op_q    <= winner ? req1_op : req0_op;
            rsp_id  <= winner;
            rr_last <= winner;
            cnt     <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data <= sel_result(op_q, alu_R, alu_S, alu_T, alu_U, alu_V,
                                   alu_W, alu_X, alu_Y, alu_Z);
          end
        end
        RESP: begin
          // rsp_data and rsp_id hold until the handshake
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex2_arbiter.sv
// Randomized self-checking bench for ex2_arbiter with a transaction-level reference model
// and a stub ex2 unit driven from alu_P/alu_Q.
module tb_ex2_arbiter;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [4:0] req0_P, req0_Q, req1_P, req1_Q;
  logic [2:0] req0_op, req1_op;
  logic [4:0] alu_P, alu_Q;
  logic [6:0] alu_R;
  logic [3:0] alu_S;
  logic [7:0] alu_T;
  logic [4:0] alu_U, alu_V, alu_X;
  logic [5:0] alu_W;
  logic       alu_Y, alu_Z;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;
  logic m_rr_last;

  always #5 clk = ~clk;

  assign alu_T = {alu_P[2:0], alu_Q};
  assign alu_R = {2'b00, alu_P};
  assign alu_S = alu_Q[3:0];
  assign alu_Y = ^alu_P;
  assign alu_Z = ^alu_Q;
  assign alu_U = alu_P;
  assign alu_V = alu_P;
  assign alu_W = {1'b0, alu_P};
  assign alu_X = alu_P;

  ex2_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_P(req0_P), .req0_Q(req0_Q), .req0_op(req0_op),
    .req1_P(req1_P), .req1_Q(req1_Q), .req1_op(req1_op),
    .alu_P(alu_P), .alu_Q(alu_Q),
    .alu_R(alu_R), .alu_S(alu_S), .alu_T(alu_T), .alu_U(alu_U), .alu_V(alu_V),
    .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y), .alu_Z(alu_Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_winner(input logic [1:0] v, input logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
`ifdef EX2_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~last;
`endif
  endfunction

  // Expected response straight from the stub definitions and the select table
  function automatic logic [7:0] exp_result(input logic [4:0] p, input logic [4:0] q,
                                            input logic [2:0] op);
    int v;
    case (op)
      3'd1:    v = q % 16;
      3'd2:    v = (p % 8) * 32 + q;
      3'd7:    v = 2 * int'(^q) + int'(^p);
      default: v = p;
    endcase
    return 8'(v);
  endfunction

  task automatic scramble_requests();
    req_valid = 2'($urandom_range(0, 3));
    req0_P = 5'($urandom); req0_Q = 5'($urandom); req0_op = 3'($urandom);
    req1_P = 5'($urandom); req1_Q = 5'($urandom); req1_op = 3'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic do_op(input logic [1:0] mask,
                       input logic [4:0] p0, input logic [4:0] q0, input logic [2:0] o0,
                       input logic [4:0] p1, input logic [4:0] q1, input logic [2:0] o1,
                       input int bp);
    logic       w;
    logic [4:0] ep, eq;
    logic [7:0] ed;
    int         neg;
    req_valid = mask;
    req0_P = p0; req0_Q = q0; req0_op = o0;
    req1_P = p1; req1_Q = q1; req1_op = o1;
    rsp_ready = 1'($urandom_range(0, 1));
    w  = exp_winner(mask, m_rr_last);
    ep = w ? p1 : p0;
    eq = w ? q1 : q0;
    ed = exp_result(ep, eq, w ? o1 : o0);
    #1;
    chk("grant", req_ready, w ? 2'b10 : 2'b01);
    chk("busy_idle", busy, 1'b0);
    @(posedge clk);
    m_rr_last = w;
    neg = 0;
    while (1) begin
      @(negedge clk);
      neg++;
      if (neg == 1) begin
        chk("alu_P", alu_P, ep);
        chk("alu_Q", alu_Q, eq);
      end
      if (rsp_valid || neg >= 20) break;
      chk("ready_settle", req_ready, 2'b00);
      chk("busy_settle", busy, 1'b1);
      rsp_ready = 1'($urandom_range(0, 1));
      scramble_requests();
    end
    chk("latency", neg - 1, SETTLE);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_id", rsp_id, w);
    for (int i = 0; i < bp; i++) begin
      rsp_ready = 1'b0;
      scramble_requests();
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, ed);
      chk("bp_ready", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", rsp_valid, 1'b0);
    chk("done_busy", busy, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    req0_P = 5'd0; req0_Q = 5'd0; req0_op = 3'd0;
    req1_P = 5'd0; req1_Q = 5'd0; req1_op = 3'd0;
    m_rr_last = 1'b1;
    @(negedge clk);
    chk("rst_alu_P", alu_P, 5'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin, then single request, backpressure and select corners
    for (int i = 0; i < 4; i++)
      do_op(2'b11, 5'b00011, 5'd0, 3'd0, 5'b11100, 5'd0, 3'd0, 0);
    do_op(2'b01, 5'b01010, 5'b10101, 3'd2, 5'd0, 5'd0, 3'd0, 0);
    chk("single_data", rsp_data, 8'h55);
    do_op(2'b10, 5'd7, 5'd9, 3'd5, 5'd17, 5'd4, 3'd2, 5);
    do_op(2'b01, 5'b00011, 5'b11100, 3'd7, 5'd0, 5'd0, 3'd0, 1);
    do_op(2'b01, 5'b00011, 5'b11100, 3'd1, 5'd0, 5'd0, 3'd0, 0);

    // Reset one cycle after an accept
    req_valid = 2'b10; req1_P = 5'd21; req1_Q = 5'd6; req1_op = 3'd2;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    m_rr_last = 1'b1;
    chk("mid_rst_alu_P", alu_P, 5'd0);
    chk("mid_rst_alu_Q", alu_Q, 5'd0);
    chk("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", rsp_valid, 1'b0);
    end
    do_op(2'b11, 5'd9, 5'd3, 3'd0, 5'd30, 5'd1, 3'd0, 0);
    chk("post_rst_id", rsp_id, 1'b0);

    for (int n = 0; n < 200; n++)
      do_op(2'($urandom_range(1, 3)),
            5'($urandom), 5'($urandom), 3'($urandom),
            5'($urandom), 5'($urandom), 3'($urandom),
            int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
